// File: rtl/parity_tx_pkg.sv
// Shared types and line levels for the parity serial transmitter.
package parity_tx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/parity_serial_tx_bit_timer.sv
// Per-bit cycle counter: pulses bit_end on the last clock of each serial bit.
module bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic bit_end,
    output logic bit_pre_end
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt <= '0;
        else if (run)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign bit_end     = run && (cnt == LAST);
    // One cycle early so registered outputs can line up with the bit's last cycle.
    assign bit_pre_end = run && (cnt == PRE);
endmodule

// File: rtl/parity_serial_tx.sv
// Frames a parallel word as start, data (LSB first), parity, stop on a serial line.
module parity_serial_tx
    import parity_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              odd_en,
    output logic              data_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);
    localparam int IW = $clog2(DATA_W);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    tx_state_t         state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [IW-1:0]     idx, idx_n;
    logic              par, par_n;
    logic              tx_n, busy_n, done_n;
    logic              accept, run, bit_end, bit_pre_end;

    assign data_ready = (state == IDLE) && !rst;
    assign accept     = data_valid && data_ready;
    assign run        = (state != IDLE);

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clear       (accept),
        .run         (run),
        .bit_end     (bit_end),
        .bit_pre_end (bit_pre_end)
    );

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n   = idx;
        par_n   = par;
        case (state)
            IDLE: if (accept) begin
                state_n = START;
                shreg_n = data_in;
                idx_n   = '0;
                par_n   = odd_en ? ~^data_in : ^data_in;
            end
            START:  if (bit_end) state_n = DATA;
            DATA: if (bit_end) begin
                if (idx == LAST_IDX) begin
                    state_n = PARITY;
                end else begin
                    shreg_n = shreg >> 1;
                    idx_n   = idx + 1'b1;
                end
            end
            PARITY: if (bit_end) state_n = STOP;
            STOP:   if (bit_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Outputs are registered from next-state values so the line changes on the edge.
        case (state_n)
            START:   tx_n = START_BIT;
            DATA:    tx_n = shreg_n[0];
            PARITY:  tx_n = par_n;
            STOP:    tx_n = STOP_BIT;
            default: tx_n = LINE_IDLE;
        endcase
        busy_n = (state_n != IDLE);
        done_n = (state == STOP) && bit_pre_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            idx        <= '0;
            par        <= 1'b0;
            tx_out     <= LINE_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            idx        <= idx_n;
            par        <= par_n;
            tx_out     <= tx_n;
            busy       <= busy_n;
            frame_done <= done_n;
        end
    end
endmodule

// File: tb/tb_parity_serial_tx.sv
// Scoreboard bench: stimulus queues expected words, a negedge monitor checks each frame.
module tb_parity_serial_tx;
    localparam int DATA_W = 8;
    localparam int CPB    = 4;
    localparam int FRAME  = (DATA_W + 3) * CPB;

    logic              clk, rst, data_valid, odd_en;
    logic [DATA_W-1:0] data_in;
    logic              data_ready, tx_out, busy, frame_done;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              odd;
    } exp_t;

    exp_t exp_q[$];
    int   fd_stamps[$];
    int   tests = 0;
    int   fails = 0;
    bit   abort = 0;
    bit   mon_active = 0;

    parity_serial_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .odd_en     (odd_en),
        .data_ready (data_ready),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: start, data LSB first, parity making total ones even/odd, stop.
    function automatic logic [DATA_W+2:0] ref_frame(input exp_t e);
        logic [DATA_W+2:0] f;
        int ones;
        ones = $countones(e.d);
        f[0] = 1'b0;
        for (int i = 0; i < DATA_W; i++) f[1+i] = e.d[i];
        f[DATA_W+1] = e.odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
        f[DATA_W+2] = 1'b1;
        return f;
    endfunction

    initial begin : monitor
        int c, cyc;
        logic [DATA_W+2:0] fb;
        exp_t e;
        cyc = 0;
        c = 0;
        fb = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (abort) begin
                mon_active = 0;
            end else if (!mon_active) begin
                if (busy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", {7'd0, busy}, 8'd0);
                    end else begin
                        e = exp_q.pop_front();
                        fb = ref_frame(e);
                        mon_active = 1;
                        c = 0;
                    end
                end else if (tx_out !== 1'b1 || frame_done !== 1'b0) begin
                    chk("idle_line", {6'd0, tx_out, frame_done}, 8'h02);
                end
            end
            if (mon_active) begin
                chk("frame", {5'd0, busy, tx_out, frame_done},
                    {5'd0, 1'b1, fb[c / CPB], 1'(c == FRAME - 1)});
                if (c == FRAME - 1) begin
                    fd_stamps.push_back(cyc);
                    mon_active = 0;
                end
                c++;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [DATA_W-1:0] d, input logic odd, input bit hold);
        int n;
        bit ok;
        exp_t e;
        data_in = d;
        odd_en = odd;
        data_valid = 1;
        n = 0;
        ok = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (data_ready) ok = 1;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            chk("accept_timeout", 8'd0, 8'd1);
        end else begin
            e.d = d;
            e.odd = odd;
            exp_q.push_back(e);
        end
        if (!hold) data_valid = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || mon_active || busy) && n < 1000);
        if (n >= 1000) chk("idle_timeout", 8'd0, 8'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin : stim
        rst = 1;
        data_valid = 0;
        data_in = '0;
        odd_en = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {4'd0, tx_out, busy, frame_done, data_ready}, 8'b1000);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("ready_after_reset", {7'd0, data_ready}, 8'd1);
        @(posedge clk);
        #1;

        send(8'hA5, 1'b0, 0);
        wait_idle();

        send(8'h07, 1'b1, 0);
        send(8'h07, 1'b0, 0);
        send(8'h00, 1'b1, 0);
        send(8'hFF, 1'b0, 0);
        wait_idle();

        // Inputs wiggled mid-frame must neither alter the frame nor be accepted.
        send(8'hA5, 1'b0, 0);
        for (int k = 0; k < 10; k++) begin
            repeat (3) @(posedge clk);
            #1;
            data_in = 8'h3C;
            odd_en = 1'b1;
            data_valid = 1;
            @(negedge clk);
            chk("ready_while_busy", {7'd0, data_ready}, 8'd0);
            @(posedge clk);
            #1 data_valid = 0;
        end
        wait_idle();

        send(8'h11, 1'b0, 1);
        send(8'h22, 1'b0, 0);
        wait_idle();
        if (fd_stamps.size() >= 2)
            chk("b2b_gap", 8'(fd_stamps[$] - fd_stamps[$-1]), 8'(FRAME + 1));
        else
            chk("b2b_frames", 8'(fd_stamps.size()), 8'd2);

        // Reset during data bit 3 (cycles 16..19 after accept).
        send(8'h5A, 1'b1, 0);
        repeat (16) @(posedge clk);
        #1;
        abort = 1;
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_midframe", {4'd0, tx_out, busy, frame_done, data_ready}, 8'b1001);
        abort = 0;
        repeat (60) @(posedge clk);
        #1;

        rst = 1;
        data_valid = 1;
        data_in = 8'h99;
        @(negedge clk);
        chk("rst_valid_ready", {6'd0, data_ready, tx_out}, 8'b01);
        @(posedge clk);
        #1;
        rst = 0;
        data_valid = 0;
        @(negedge clk);
        chk("rst_valid_noaccept", {6'd0, tx_out, busy}, 8'b10);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge clk);
            #1;
            send(8'($urandom), 1'($urandom), 0);
        end
        wait_idle();
        chk("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/parity_serial_tx.md
# parity_serial_tx

Serial framing stage directly downstream of the parity generator. It accepts a parallel data word over a valid/ready handshake and computes the even or odd parity bit for that word. It then shifts out a single-line frame, LSB first: start bit, data, parity, stop. This is the block that drives the serial link output pin.

## Interface
- `DATA_W`, default 8: data word width; must be ≥ 2.
- `CLKS_PER_BIT`, default 16: clock cycles each serial bit is held; must be ≥ 2.
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `data_in`, input, `DATA_W`: word to transmit; sampled only on handshake.
- `data_valid`, input, 1: upstream has a word.
- `odd_en`, input, 1: 1 selects odd parity, 0 selects even; sampled with `data_in`.
- `data_ready`, output, 1: block can accept a word this cycle.
- `tx_out`, output, 1: serial line; idles high.
- `busy`, output, 1: a frame is in progress.
- `frame_done`, output, 1: one-cycle pulse on the last cycle of the stop bit.

## Operation
- **Handshake:**
  - Accept occurs when `data_valid && data_ready`.
  - `data_ready = (state == IDLE) && !rst`.
- **On accept:**
  - Latch `data_in` into the shift register.
  - Latch the parity bit: `^data_in` when `odd_en = 0`, `~^data_in` when `odd_en = 1`.
  - Later changes to `data_in` or `odd_en` have no effect on the frame.
- **FSM states:** IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE: `tx_out = 1`, `busy = 0`. Accept moves to START.
  - START: `tx_out = 0`.
  - DATA: `tx_out = shreg[0]`. Shift right at each bit end. After `DATA_W` bits, go to PARITY.
  - PARITY: `tx_out` = latched parity bit.
  - STOP: `tx_out = 1`. `frame_done` is asserted on its final cycle, then the FSM returns to IDLE.
- **Bit timer:**
  - Counter width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT-1`.
  - `bit_end` asserts at `CLKS_PER_BIT-1`, and the counter wraps to 0.
  - The counter is cleared on accept.
- **Bit index:** width `$clog2(DATA_W)`. DATA exits when the index reaches `DATA_W-1` and `bit_end` is asserted.
- **Ignored inputs:** `data_valid` is ignored whenever `busy` is high. No queuing, no error flag.
- **Registered outputs:** `tx_out`, `busy` and `frame_done` are registered. Reset values are `tx_out = 1`, `busy = 0`, `frame_done = 0`; `data_ready` is 0 while `rst` is high.
- **Reset mid-frame:** the FSM goes to IDLE at the next edge. `tx_out` returns high, the frame is abandoned, and no `frame_done` is issued.
- **Reset with valid:** reset has priority over a simultaneous `data_valid`; no accept occurs.

## Timing
- Latency from accept edge to the first START cycle on `tx_out`: 1 clock.
- Frame length: `(DATA_W + 3) * CLKS_PER_BIT` clocks, from the first START cycle to the last STOP cycle inclusive.
- `frame_done` is high on exactly 1 cycle, coincident with the last STOP cycle.
- `busy` is high from the first START cycle through the last STOP cycle.
- Back-to-back frames with `data_valid` held high:
  - IDLE lasts exactly 1 cycle: `tx_out = 1`, `data_ready = 1`, and the accept happens in that cycle.
  - The next START follows on the cycle after.
  - The minimum gap between frames is therefore 1 idle-high cycle.
- After `rst` deasserts, the first cycle with `rst` low already has `data_ready = 1`.

## Structure
- Shared package `parity_tx_pkg` holds:
  - `tx_state_t` enum {IDLE, START, DATA, PARITY, STOP}.
  - Localparams `LINE_IDLE = 1'b1`, `START_BIT = 1'b0`, `STOP_BIT = 1'b1`.
- One sub-module, `bit_timer`. It is parameterised by `CLKS_PER_BIT`, with inputs `clk`, `rst`, `clear`, `run` and output pulse `bit_end`.
- FSM, shift register, bit index and parity latch stay in the top module.

## Test plan
Bench parameters: `DATA_W = 8`, `CLKS_PER_BIT = 4`.
- **Even parity frame:** accept `0xA5`, `odd_en = 0` → `tx_out` holds 0,1,0,1,0,0,1,0,1,0,1, each for 4 clocks. `frame_done` pulses on clock 44 after accept; `busy` is high for 44 cycles.
- **Parity select:** `0x07` with `odd_en = 1` → parity bit 0. `0x07` with `odd_en = 0` → parity bit 1. `0x00` with `odd_en = 1` → parity bit 1. `0xFF` with `odd_en = 0` → parity bit 0.
- **Input isolation:** change `data_in` to `0x3C` and pulse `data_valid` during the frame of `0xA5` → serialized bits are unchanged, `data_ready` stays 0, and no second frame starts.
- **Back-to-back:** hold `data_valid` high with `0x11` then `0x22` → exactly 1 idle-high cycle between the two STOP/START boundaries, and 2 `frame_done` pulses 45 clocks apart.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 3 → the next cycle shows `tx_out = 1`, `busy = 0`, no `frame_done`. `data_ready = 1` in the first cycle after `rst` drops.
- **Reset with valid:** assert `rst` and `data_valid` together → no accept; `tx_out` stays 1.
